// File: rtl/wb_streamer_pkg.sv
// Shared definitions for the stream writer Wishbone engine.
// No logic: cycle-type / burst-type constants and the controller state enum.
// No backpressure: pure type and constant declarations.
package wb_streamer_pkg;

  // Wishbone registered-feedback cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type: linear incrementing
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_t;

endpackage

// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone burst-read engine: fetches a buffer in incrementing bursts and pushes each word into the output FIFO.
// Latency: enable -> first strobe two cycles later at the earliest; one beat per cycle with a zero-wait slave.
// Backpressure: a burst only starts once the FIFO has room for every beat of it; slave stalls hold strobe high.
module wb_stream_writer_ctrl
  import wb_streamer_pkg::*;
#(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic [WB_DW-1:0]     fifo_d_o,
  output logic                 fifo_wr_o,
  input  logic [FIFO_AW:0]     fifo_cnt_i,
  output logic                 busy_o,
  output logic                 irq_o,
  output logic                 err_o
);

  // Counters sized to hold a full FIFO's worth of beats (0..2^FIFO_AW)
  localparam int              CW      = FIFO_AW + 1;
  localparam logic [CW-1:0]   DEPTH   = CW'(2**FIFO_AW);
  localparam logic [WB_AW-1:0] DEPTH_A = WB_AW'(2**FIFO_AW);
  localparam logic [WB_AW-1:0] STRIDE  = WB_AW'(WB_DW/8);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WB_AW-1:0] r_adr;
  logic [WB_AW-1:0] r_remaining;
  logic [CW-1:0]    r_blen;
  logic [CW-1:0]    r_beat_cnt;
  logic             r_err;

  logic [CW-1:0]    w_free;
  logic [CW-1:0]    w_beats;
  logic [CW-1:0]    w_blen_lat;
  logic             w_start;
  logic             w_burst_go;
  logic             w_ack;
  logic             w_err_beat;
  logic             w_last_beat;

  // Enable is only honoured from IDLE; anything arriving while busy is dropped
  assign w_start     = (r_state == IDLE) && enable;
  assign w_free      = DEPTH - fifo_cnt_i;
  assign w_beats     = (r_remaining < WB_AW'(r_blen)) ? r_remaining[CW-1:0] : r_blen;
  assign w_burst_go  = (r_state == WAIT) && (w_free >= w_beats);
  // Error takes priority over a simultaneous ack: that beat is discarded
  assign w_err_beat  = (r_state == BURST) && wbm_err_i;
  assign w_ack       = (r_state == BURST) && wbm_ack_i && !wbm_err_i;
  assign w_last_beat = (r_beat_cnt == CW'(1));

  // Burst length on latch: zero means one beat, and never more than the FIFO can hold
  always_comb begin
    w_blen_lat = burst_size[CW-1:0];
    if (burst_size == '0) begin
      w_blen_lat = CW'(1);
    end else if (burst_size > DEPTH_A) begin
      w_blen_lat = DEPTH;
    end
  end

  // State register; reset drops cyc/stb immediately through the state decode
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and bus/status output decode
  always_comb begin
    w_state_nxt = r_state;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_cti_o   = CTI_CLASSIC;
    irq_o       = 1'b0;
    busy_o      = (r_state != IDLE);
    fifo_wr_o   = w_ack;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = (buf_size == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (w_burst_go) begin
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_cti_o = w_last_beat ? CTI_EOB : CTI_INC;
        if (wbm_err_i) begin
          w_state_nxt = DONE;
        end else if (wbm_ack_i && w_last_beat) begin
          w_state_nxt = (r_remaining == WB_AW'(1)) ? DONE : WAIT;
        end
      end
      DONE: begin
        irq_o       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transfer bookkeeping: address, words left, beats left in burst, sticky error
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_adr       <= '0;
      r_remaining <= '0;
      r_blen      <= CW'(1);
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_start) begin
        r_adr       <= start_adr;
        r_remaining <= buf_size;
        r_blen      <= w_blen_lat;
        r_err       <= 1'b0;
      end
      if (w_burst_go) begin
        r_beat_cnt <= w_beats;
      end
      if (w_ack) begin
        r_adr       <= r_adr + STRIDE;
        r_remaining <= r_remaining - WB_AW'(1);
        r_beat_cnt  <= r_beat_cnt - CW'(1);
      end
      if (w_err_beat) begin
        r_err <= 1'b1;
      end
    end
  end

  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_bte_o = BTE_LINEAR;
  assign fifo_d_o  = wbm_dat_i;
  assign err_o     = r_err;

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Bench for wb_stream_writer_ctrl: directed scenarios plus randomized transfers against a beat-list model.
// The model expands each transfer into its expected beats (address, cti, burst length) and predicts bus timing.
// A slave process drives ack/err/data and the FIFO level each cycle; a monitor compares at mid-cycle.
module tb_wb_stream_writer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] start_adr = '0;
  logic [31:0] buf_size = '0;
  logic [31:0] burst_size = '0;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;
  logic [31:0] fifo_d;
  logic        fifo_wr;
  logic [5:0]  fifo_cnt = '0;
  logic        busy_o, irq_o, err_o;

  always #5 clk = ~clk;

  wb_stream_writer_ctrl dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable(enable),
    .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_sel_o(sel_o), .wbm_we_o(we_o),
    .wbm_cyc_o(cyc_o), .wbm_stb_o(stb_o), .wbm_cti_o(cti_o), .wbm_bte_o(bte_o),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack_i), .wbm_err_i(err_i),
    .fifo_d_o(fifo_d), .fifo_wr_o(fifo_wr), .fifo_cnt_i(fifo_cnt),
    .busy_o(busy_o), .irq_o(irq_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    int          blen;
  } beat_t;

  beat_t q[$];
  beat_t cur;
  int    n_chk = 0;
  int    n_pass = 0;
  int    irq_cnt = 0;
  int    fw_cnt = 0;
  int    exp_wr = 0;
  int    err_idx = -1;
  int    sbeat = 0;
  bit    zero_wait = 1'b1;
  bit    fifo_mode = 1'b1;
  logic [5:0] fifo_fix = '0;
  // model state for the current cycle
  bit    mb = 1'b0, e_cyc = 1'b0, e_irq = 1'b0, e_err = 1'b0;
  bit    n_mb, n_cyc, n_irq, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Slave + FIFO driver at the falling edge, then compare against the model 3ns later
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_i = 1'b0; err_i = 1'b0; sbeat = 0;
    end else begin
      dat_i = $urandom;
      if (stb_o) begin
        if (sbeat == err_idx) begin
          err_i = 1'b1; ack_i = 1'($urandom % 2); err_idx = -1;
        end else begin
          err_i = 1'b0;
          ack_i = zero_wait ? 1'b1 : ($urandom % 3 != 0);
          if (ack_i) sbeat++;
        end
      end else begin
        err_i = 1'b0;
        ack_i = ($urandom % 8 == 0);
      end
      fifo_cnt = fifo_mode ? fifo_fix : (($urandom % 2 == 0) ? 6'd0 : 6'($urandom_range(0, 32)));
    end
    #3;
    if (!rst_n) begin
      q.delete(); mb = 0; e_cyc = 0; e_irq = 0; e_err = 0;
    end else begin
      chk("cyc", cyc_o, e_cyc);
      chk("stb", stb_o, e_cyc);
      chk("busy", busy_o, mb);
      chk("irq", irq_o, e_irq);
      chk("err_flag", err_o, e_err);
      if (irq_o) irq_cnt++;
      if (fifo_wr) fw_cnt++;
      n_mb = e_irq ? 1'b0 : mb;
      n_err = e_err; n_irq = 0; n_cyc = 0;
      if (enable && !mb) begin
        n_mb = 1; n_err = 0;
        if (q.size() == 0) n_irq = 1;
      end
      if (e_cyc && q.size() > 0) begin
        cur = q[0];
        chk("adr", adr_o, cur.adr);
        chk("cti", cti_o, cur.cti);
        if (err_i) begin
          q.delete(); n_err = 1; n_irq = 1;
          chk("fifo_wr_on_err", fifo_wr, 0);
        end else if (ack_i) begin
          chk("fifo_wr", fifo_wr, 1);
          chk("fifo_d", fifo_d, dat_i);
          void'(q.pop_front());
          n_cyc = (cur.cti != 3'b111);
          if (q.size() == 0) n_irq = 1;
        end else begin
          chk("fifo_wr_stall", fifo_wr, 0);
          n_cyc = 1;
        end
      end else begin
        chk("fifo_wr_idle", fifo_wr, 0);
        if (mb && !e_irq && q.size() > 0) begin
          if (32 - int'(fifo_cnt) >= q[0].blen) n_cyc = 1;
        end
      end
      mb = n_mb; e_cyc = n_cyc; e_irq = n_irq; e_err = n_err;
    end
  end

  // Load the expected beat list for one transfer and pulse enable
  task automatic start_xfer(input logic [31:0] sa, input int size, input logic [31:0] bsz, input int eidx);
    int eff, base, len;
    beat_t b;
    @(negedge clk);
    eff = (bsz == 0) ? 1 : ((bsz > 32) ? 32 : int'(bsz));
    for (int k = 0; k < size; k++) begin
      base   = (k / eff) * eff;
      len    = (size - base < eff) ? (size - base) : eff;
      b.adr  = sa + 32'(4 * k);
      b.cti  = (k - base == len - 1) ? 3'b111 : 3'b010;
      b.blen = len;
      q.push_back(b);
    end
    exp_wr = (eidx >= 0 && eidx < size) ? eidx : size;
    err_idx = eidx; sbeat = 0; irq_cnt = 0; fw_cnt = 0;
    start_adr = sa; buf_size = 32'(size); burst_size = bsz; enable = 1'b1;
  endtask

  // Run until the model goes idle; optionally throw stray enables at the busy engine
  task automatic wait_xfer(input bit spur);
    int w;
    for (w = 0; w < 4000; w++) begin
      @(negedge clk);
      enable = 1'b0;
      if (!mb && q.size() == 0) break;
      if (spur && mb && ($urandom % 16 == 0)) begin
        enable = 1'b1; start_adr = $urandom;
        buf_size = $urandom_range(0, 5); burst_size = $urandom_range(0, 3);
      end
    end
    enable = 1'b0;
    chk("xfer_timeout", (w < 4000), 1);
    chk("irq_count", irq_cnt, 1);
    chk("fifo_writes", fw_cnt, exp_wr);
  endtask

  initial begin
    logic [31:0] sa, bsz;
    int size, eidx, w;
    repeat (2) @(negedge clk);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_cti", cti_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    #1 rst_n = 1'b1;

    // two 4-beat bursts, empty FIFO, zero-wait slave
    start_xfer(32'h1000, 8, 4, -1);
    wait_xfer(0);
    chk("err_after_ok", err_o, 0);
    // 4 + 4 + 2, with slave wait states
    zero_wait = 0;
    start_xfer(32'h2000, 10, 4, -1);
    wait_xfer(0);
    // FIFO nearly full holds the burst off until 4 words are free
    fifo_fix = 6'd30;
    start_xfer(32'h3000, 8, 4, -1);
    repeat (8) @(negedge clk);
    enable = 1'b0;
    chk("cyc_held_low", cyc_o, 0);
    fifo_fix = 6'd28;
    wait_xfer(0);
    // error on the third beat of four
    fifo_fix = 6'd0; zero_wait = 1;
    start_xfer(32'h4000, 4, 4, 2);
    wait_xfer(0);
    chk("err_set", err_o, 1);
    start_xfer(32'h4100, 2, 1, -1);
    @(negedge clk);
    enable = 1'b0;
    chk("err_cleared", err_o, 0);
    wait_xfer(0);
    // empty buffer, then zero burst size
    start_xfer(32'h5000, 0, 4, -1);
    wait_xfer(0);
    start_xfer(32'h6000, 3, 0, -1);
    wait_xfer(0);
    // stray enable while busy, then reset in the middle of a burst
    start_xfer(32'h7000, 16, 8, -1);
    @(negedge clk);
    enable = 1'b0;
    for (w = 0; w < 50 && !cyc_o; w++) @(negedge clk);
    chk("burst_started", cyc_o, 1);
    enable = 1'b1; start_adr = 32'hDEAD_0000; buf_size = 32'd2; burst_size = 32'd1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    #1 ack_i = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", cyc_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_fifo_wr", fifo_wr, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    start_xfer(32'h7100, 5, 2, -1);
    wait_xfer(0);

    // randomized transfers
    fifo_mode = 0;
    for (int t = 0; t < 40; t++) begin
      zero_wait = ($urandom % 4 == 0);
      sa   = ($urandom % 4 == 0) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFC);
      size = $urandom_range(0, 70);
      bsz  = ($urandom % 10 == 0) ? $urandom : 32'($urandom_range(0, 40));
      eidx = (size > 0 && ($urandom % 5 == 0)) ? $urandom_range(0, size - 1) : -1;
      start_xfer(sa, size, bsz, eidx);
      wait_xfer(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
